// File: rtl/assembler_constants.sv
// Shared constants, types and character helpers for the assembler front end.
package assembler_constants;

    // Error report attached to a parsed operand.
    typedef struct packed {
        logic [7:0] line;
        logic       error_flag;
    } Error;

    // Characters that end an operand.
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_TAB    = 8'h09;
    localparam logic [7:0] CH_LPAREN = 8'h28;
    localparam logic [7:0] CH_RPAREN = 8'h29;
    localparam logic [7:0] CH_NL     = 8'h0A;
    localparam logic [7:0] CH_NUL    = 8'h00;

    // Operand parser states.
    typedef enum logic [2:0] {
        IDLE,
        SIGN,
        ZERO,
        DEC,
        HEX,
        REG,
        ERR,
        EMIT
    } ParseState;

    function automatic logic isTerm(input logic [7:0] c);
        return (c == CH_COMMA) || (c == CH_SPACE) || (c == CH_TAB) ||
               (c == CH_LPAREN) || (c == CH_RPAREN) || (c == CH_NL) ||
               (c == CH_NUL);
    endfunction

    function automatic logic isNum(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic isAlpha(input logic [7:0] c);
        return ((c >= 8'h61) && (c <= 8'h7A)) || ((c >= 8'h41) && (c <= 8'h5A));
    endfunction

    function automatic logic isHex(input logic [7:0] c);
        return isNum(c) || ((c >= 8'h61) && (c <= 8'h66)) ||
               ((c >= 8'h41) && (c <= 8'h46));
    endfunction

    // Nibble value of a hex digit; decimal digits map to themselves.
    function automatic logic [3:0] ascii_to_hex(input logic [7:0] c);
        logic [7:0] t;
        if (isNum(c)) begin
            t = c - 8'h30;
        end else if ((c >= 8'h61) && (c <= 8'h66)) begin
            t = c - 8'h57;
        end else begin
            t = c - 8'h37;
        end
        return t[3:0];
    endfunction

endpackage

// File: rtl/operand_parser.sv
// Streaming ASCII operand parser: one character per cycle in, one register
// index or 32-bit immediate out, plus the character that terminated it.
//
// Handshake: a character moves when char_valid_in and char_ready_out are both
// high on a rising clk_in edge; char_ready_out depends only on the state and
// drops for the single EMIT cycle in which result_valid_out pulses.
module operand_parser
    import assembler_constants::*;
#(
    parameter int MAX_HEX_DIGITS = 8,
    parameter int MAX_DEC_DIGITS = 10
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       char_valid_in,
    input  logic [7:0] char_in,
    output logic       char_ready_out,
    input  logic [7:0] line_in,
    output logic       result_valid_out,
    output logic       is_reg_out,
    output logic [4:0] reg_out,
    output logic [31:0] imm_out,
    output logic [7:0] term_char_out,
    output Error       error_out,
    output ParseState  state_dbg_out
);

    localparam logic [4:0] MAX_HEX = 5'(MAX_HEX_DIGITS);
    localparam logic [4:0] MAX_DEC = 5'(MAX_DEC_DIGITS);

    ParseState   state, state_nxt;
    logic [31:0] acc, acc_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic        neg, neg_nxt;
    logic        is_reg, is_reg_nxt;
    logic        err, err_nxt;
    logic [7:0]  err_line;
    logic        emit;

    logic        accept;
    logic [3:0]  digit;
    logic [31:0] acc_dec;
    logic [31:0] acc_hex;
    logic [31:0] value;

    assign accept           = char_valid_in && char_ready_out;
    assign char_ready_out   = (state != EMIT);
    assign result_valid_out = (state == EMIT);
    assign state_dbg_out    = state;

    // Both accumulator candidates; the FSM picks one per character.
    assign digit   = ascii_to_hex(char_in);
    assign acc_dec = (acc << 3) + (acc << 1) + {28'd0, digit};
    assign acc_hex = {acc[27:0], digit};
    assign value   = neg ? (~acc + 32'd1) : acc;

    // Next-state and accumulator update for the accepted character.
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        neg_nxt    = neg;
        is_reg_nxt = is_reg;
        err_nxt    = err;
        emit       = 1'b0;
        if (state == EMIT) begin
            state_nxt  = IDLE;
            acc_nxt    = '0;
            cnt_nxt    = '0;
            neg_nxt    = 1'b0;
            is_reg_nxt = 1'b0;
            err_nxt    = 1'b0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if ((char_in == CH_SPACE) || (char_in == CH_TAB)) begin
                        state_nxt = IDLE;
                    end else if (char_in == "x") begin
                        state_nxt  = REG;
                        is_reg_nxt = 1'b1;
                    end else if (char_in == "-") begin
                        state_nxt = SIGN;
                        neg_nxt   = 1'b1;
                    end else if (char_in == "0") begin
                        state_nxt = ZERO;
                    end else if (isNum(char_in)) begin
                        state_nxt = DEC;
                        acc_nxt   = {28'd0, digit};
                        cnt_nxt   = 5'd1;
                    end else if (isTerm(char_in)) begin
                        emit    = 1'b1;
                        err_nxt = 1'b1;
                    end else begin
                        state_nxt = ERR;
                        err_nxt   = 1'b1;
                    end
                end
                SIGN: begin
                    if (isNum(char_in)) begin
                        state_nxt = DEC;
                        acc_nxt   = {28'd0, digit};
                        cnt_nxt   = 5'd1;
                    end else if (isTerm(char_in)) begin
                        emit    = 1'b1;
                        err_nxt = 1'b1;
                    end else begin
                        state_nxt = ERR;
                        err_nxt   = 1'b1;
                    end
                end
                ZERO: begin
                    if ((char_in == "x") || (char_in == "X")) begin
                        state_nxt = HEX;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                    end else if (isNum(char_in)) begin
                        // The leading zero counts toward the digit limit.
                        state_nxt = DEC;
                        acc_nxt   = {28'd0, digit};
                        cnt_nxt   = 5'd2;
                    end else if (isTerm(char_in)) begin
                        emit = 1'b1;
                    end else begin
                        state_nxt = ERR;
                        err_nxt   = 1'b1;
                    end
                end
                DEC: begin
                    if (isNum(char_in)) begin
                        if (cnt >= MAX_DEC) begin
                            state_nxt = ERR;
                            err_nxt   = 1'b1;
                        end else begin
                            acc_nxt = acc_dec;
                            cnt_nxt = cnt + 5'd1;
                        end
                    end else if (isTerm(char_in)) begin
                        emit = 1'b1;
                    end else begin
                        state_nxt = ERR;
                        err_nxt   = 1'b1;
                    end
                end
                HEX: begin
                    if (isHex(char_in)) begin
                        if (cnt >= MAX_HEX) begin
                            state_nxt = ERR;
                            err_nxt   = 1'b1;
                        end else begin
                            acc_nxt = acc_hex;
                            cnt_nxt = cnt + 5'd1;
                        end
                    end else if (isTerm(char_in)) begin
                        emit    = 1'b1;
                        err_nxt = (cnt == 5'd0);
                    end else begin
                        state_nxt = ERR;
                        err_nxt   = 1'b1;
                    end
                end
                REG: begin
                    if (isNum(char_in)) begin
                        if ((cnt >= 5'd2) || (acc_dec > 32'd31)) begin
                            state_nxt = ERR;
                            err_nxt   = 1'b1;
                        end else begin
                            acc_nxt = acc_dec;
                            cnt_nxt = cnt + 5'd1;
                        end
                    end else if (isTerm(char_in)) begin
                        emit    = 1'b1;
                        err_nxt = (cnt == 5'd0);
                    end else begin
                        state_nxt = ERR;
                        err_nxt   = 1'b1;
                    end
                end
                ERR: begin
                    if (isTerm(char_in)) begin
                        emit = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
            if (emit) begin
                state_nxt = EMIT;
            end
        end
    end

    // State, parse context and the held result registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            neg           <= 1'b0;
            is_reg        <= 1'b0;
            err           <= 1'b0;
            err_line      <= '0;
            is_reg_out    <= 1'b0;
            reg_out       <= '0;
            imm_out       <= '0;
            term_char_out <= '0;
            error_out     <= '0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            neg    <= neg_nxt;
            is_reg <= is_reg_nxt;
            err    <= err_nxt;
            // Remember where the operand first went wrong.
            if (!err && err_nxt) begin
                err_line <= line_in;
            end
            if (emit) begin
                is_reg_out    <= is_reg;
                term_char_out <= char_in;
                reg_out       <= err_nxt ? 5'd0 : acc[4:0];
                imm_out       <= err_nxt ? 32'd0 : value;
                error_out.error_flag <= err_nxt;
                error_out.line       <= err_nxt ? (err ? err_line : line_in) : 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_operand_parser.sv
// Bench for operand_parser: table of operand strings with expected results,
// a few hand-written sequences, and a pulse monitor fed by an expected queue.
module tb_operand_parser;
    import assembler_constants::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_c = 8'h00;
    logic [7:0]  line = 8'h00;
    logic        char_ready;
    logic        result_valid;
    logic        is_reg;
    logic [4:0]  reg_idx;
    logic [31:0] imm;
    logic [7:0]  term_char;
    Error        error_o;
    ParseState   state_dbg;

    operand_parser #(.MAX_HEX_DIGITS(8), .MAX_DEC_DIGITS(10)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .char_valid_in   (char_valid),
        .char_in         (char_c),
        .char_ready_out  (char_ready),
        .line_in         (line),
        .result_valid_out(result_valid),
        .is_reg_out      (is_reg),
        .reg_out         (reg_idx),
        .imm_out         (imm),
        .term_char_out   (term_char),
        .error_out       (error_o),
        .state_dbg_out   (state_dbg)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic        is_reg;
        logic [4:0]  r;
        logic [31:0] imm;
        logic [7:0]  term;
        logic        ef;
        logic [7:0]  line;
        logic [31:0] cyc;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);
    logic [EXP_W-1:0] exp_q[$];

    typedef struct {
        string      s;
        exp_t       e;
        logic [7:0] line;
        int         gap;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic ir, input logic [4:0] r, input logic [31:0] iv,
                                input logic [7:0] t, input logic ef, input logic [7:0] ln);
        exp_t e;
        e.is_reg = ir;
        e.r      = r;
        e.imm    = iv;
        e.term   = t;
        e.ef     = ef;
        e.line   = ln;
        e.cyc    = 0;
        return e;
    endfunction

    task automatic add(input string s, input exp_t e, input logic [7:0] ln, input int gap);
        vec_t v;
        v.s    = s;
        v.e    = e;
        v.line = ln;
        v.gap  = gap;
        vecs.push_back(v);
    endtask

    // Scoreboard: every result pulse is checked against the oldest expectation.
    exp_t mon_e;
    always @(negedge clk) begin
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
            end else begin
                mon_e = exp_t'(exp_q.pop_front());
                chk("pulse_cycle", cyc, mon_e.cyc);
                chk("ready_in_emit", {31'd0, char_ready}, 32'd0);
                chk("is_reg", {31'd0, is_reg}, {31'd0, mon_e.is_reg});
                if (mon_e.is_reg) chk("reg_out", {27'd0, reg_idx}, {27'd0, mon_e.r});
                chk("imm_out", imm, mon_e.imm);
                chk("term_char", {24'd0, term_char}, {24'd0, mon_e.term});
                chk("error_flag", {31'd0, error_o.error_flag}, {31'd0, mon_e.ef});
                if (mon_e.ef) chk("error_line", {24'd0, error_o.line}, {24'd0, mon_e.line});
            end
        end
    end

    // Driver: present one character and hold it until accepted.
    task automatic send_char(input logic [7:0] c, input exp_t e, input bit push);
        exp_t ee;
        int n;
        n = 0;
        @(negedge clk);
        char_valid = 1'b1;
        char_c = c;
        while (!char_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got ready=0 for %0d cycles expected ready=1", n);
        end
        if (push) begin
            ee = e;
            ee.cyc = cyc + 1;
            exp_q.push_back(ee);
        end
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic send_op(input string s, input exp_t e, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i], e, i == s.len() - 1);
            if (i != s.len() - 1) repeat (gap) @(posedge clk);
        end
    endtask

    task automatic send_raw(input string s);
        exp_t dummy;
        dummy = '0;
        for (int i = 0; i < s.len(); i++) send_char(s[i], dummy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned v;
        string s;

        add("x17,",          mk(1, 5'd17, 32'd17,        ",",   0, 8'd0), 8'd0, 0);
        add("-42(",          mk(0, 5'd0,  32'hFFFFFFD6,  "(",   0, 8'd0), 8'd0, 0);
        add("x2)",           mk(1, 5'd2,  32'd2,         ")",   0, 8'd0), 8'd0, 0);
        add("0x1aF\n",       mk(0, 5'd0,  32'h000001AF,  8'h0A, 0, 8'd0), 8'd0, 1);
        add("x32,",          mk(1, 5'd0,  32'd0,         ",",   1, 8'd5), 8'd5, 0);
        add("0x123456789,",  mk(0, 5'd0,  32'd0,         ",",   1, 8'd5), 8'd5, 0);
        add("  ,",           mk(0, 5'd0,  32'd0,         ",",   1, 8'd3), 8'd3, 0);
        add("12a4 ",         mk(0, 5'd0,  32'd0,         " ",   1, 8'd3), 8'd3, 0);
        add("-0,",           mk(0, 5'd0,  32'd0,         ",",   0, 8'd0), 8'd0, 0);
        add("-2147483648,",  mk(0, 5'd0,  32'h80000000,  ",",   0, 8'd0), 8'd0, 0);
        add("4294967295 ",   mk(0, 5'd0,  32'hFFFFFFFF,  " ",   0, 8'd0), 8'd0, 0);
        add("12345678901,",  mk(0, 5'd0,  32'd0,         ",",   1, 8'd7), 8'd7, 0);
        add("0xFFFFFFFF,",   mk(0, 5'd0,  32'hFFFFFFFF,  ",",   0, 8'd0), 8'd0, 0);
        add("0x,",           mk(0, 5'd0,  32'd0,         ",",   1, 8'd8), 8'd8, 0);
        add("0)",            mk(0, 5'd0,  32'd0,         ")",   0, 8'd0), 8'd0, 0);
        add("x0\t",          mk(1, 5'd0,  32'd0,         8'h09, 0, 8'd0), 8'd0, 0);
        add("x31)",          mk(1, 5'd31, 32'd31,        ")",   0, 8'd0), 8'd0, 0);
        add("x,",            mk(1, 5'd0,  32'd0,         ",",   1, 8'd2), 8'd2, 0);
        add("x123,",         mk(1, 5'd0,  32'd0,         ",",   1, 8'd4), 8'd4, 0);
        add("-,",            mk(0, 5'd0,  32'd0,         ",",   1, 8'd6), 8'd6, 0);
        add("-x5,",          mk(0, 5'd0,  32'd0,         ",",   1, 8'd9), 8'd9, 0);
        add("abc(",          mk(0, 5'd0,  32'd0,         "(",   1, 8'd1), 8'd1, 0);
        add("0X1f,",         mk(0, 5'd31, 32'h0000001F,  ",",   0, 8'd0), 8'd0, 0);
        add("-7 ",           mk(0, 5'd0,  32'hFFFFFFF9,  " ",   0, 8'd0), 8'd0, 2);

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, char_ready}, 32'd1);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_is_reg", {31'd0, is_reg}, 32'd0);
        chk("rst_reg", {27'd0, reg_idx}, 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_term", {24'd0, term_char}, 32'd0);
        chk("rst_error", {23'd0, error_o}, 32'd0);
        rst = 1'b0;

        foreach (vecs[k]) begin
            line = vecs[k].line;
            send_op(vecs[k].s, vecs[k].e, vecs[k].gap);
        end

        // Randomised decimal immediates and register operands.
        line = 8'd0;
        for (int k = 0; k < 6; k++) begin
            v = $urandom_range(0, 99999);
            s = $sformatf("%0d,", v);
            send_op(s, mk(0, v[4:0], v, ",", 0, 8'd0), 0);
            v = $urandom_range(0, 31);
            s = $sformatf("x%0d ", v);
            send_op(s, mk(1, v[4:0], v, " ", 0, 8'd0), 0);
        end

        // Error line is latched at the first bad character, not the terminator.
        line = 8'd9;
        send_raw("q");
        line = 8'd10;
        send_raw("5");
        send_op(",", mk(0, 5'd0, 32'd0, ",", 1, 8'd9), 0);

        // Reset in the middle of an operand discards it.
        line = 8'd0;
        send_op("0x3C,", mk(0, 5'd28, 32'h3C, ",", 0, 8'd0), 0);
        send_raw("0x12");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_imm", imm, 32'd0);
        chk("midrst_ready", {31'd0, char_ready}, 32'd1);
        rst = 1'b0;
        send_op("7,", mk(0, 5'd7, 32'd7, ",", 0, 8'd0), 0);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
